// File: rtl/saxi_count_source_if.sv
// AXI-stream channel carrying the counting source's output beats.
interface saxi_count_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  TVALID_OUT;
    logic [DATA_WIDTH-1:0] TDATA_OUT;
    logic                  TLAST_OUT;
    logic                  TREADY_OUT;

    modport master (output TVALID_OUT, TDATA_OUT, TLAST_OUT, input TREADY_OUT);
    modport slave  (input TVALID_OUT, TDATA_OUT, TLAST_OUT, output TREADY_OUT);
endinterface

// File: rtl/saxi_count_source.sv
// AXI-stream master emitting fixed-length packets of counting data, TLAST on the
// final beat, with a programmable idle gap between packets.
module saxi_count_source #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    PKT_LEN     = 16,
    parameter int                    GAP_CYCLES  = 3,
    parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] INCR        = 1
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       EN,
    saxi_count_source_if.master        axis,
    output logic                       BUSY,
    output logic [15:0]                PKT_COUNT
);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] data, data_n;
    logic [BW-1:0]         beat, beat_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [15:0]           pkt_cnt, pkt_n;
    logic                  accept, last_beat;

    assign last_beat = (beat == BW'(PKT_LEN - 1));
    assign accept    = (state == SEND) && axis.TREADY_OUT;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            data    <= START_VALUE;
            beat    <= '0;
            gap_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            state   <= state_n;
            data    <= data_n;
            beat    <= beat_n;
            gap_cnt <= gap_n;
            pkt_cnt <= pkt_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        beat_n  = beat;
        gap_n   = gap_cnt;
        pkt_n   = pkt_cnt;
        case (state)
            IDLE: if (EN) state_n = SEND;
            SEND: begin
                if (accept) begin
                    data_n = data + INCR;
                    if (last_beat) begin
                        beat_n = '0;
                        pkt_n  = pkt_cnt + 16'd1;
                        // EN is only honoured here and at the end of the gap
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            gap_n   = '0;
                        end else begin
                            state_n = EN ? SEND : IDLE;
                        end
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = EN ? SEND : IDLE;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Everything below decodes registers only, so no input reaches an output combinationally.
    assign axis.TVALID_OUT = (state == SEND);
    assign axis.TLAST_OUT  = (state == SEND) && last_beat;
    assign axis.TDATA_OUT  = data;
    assign BUSY            = (state != IDLE);
    assign PKT_COUNT       = pkt_cnt;
endmodule

// File: tb/tb_saxi_count_source.sv
// Directed bench: a 4-beat/2-gap source (A) and an 8-bit back-to-back single-beat source (B).
module tb_saxi_count_source;
    logic clk = 1'b0;
    logic rst_n;
    logic en_a, en_b;
    logic busy_a, busy_b;
    logic [15:0] pkt_a, pkt_b;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    saxi_count_source_if #(.DATA_WIDTH(32)) if_a ();
    saxi_count_source_if #(.DATA_WIDTH(8))  if_b ();

    saxi_count_source #(.DATA_WIDTH(32), .PKT_LEN(4), .GAP_CYCLES(2),
                        .START_VALUE(32'd0), .INCR(32'd1)) dut_a (
        .ACLK(clk), .ARESETn(rst_n), .EN(en_a), .axis(if_a),
        .BUSY(busy_a), .PKT_COUNT(pkt_a));

    saxi_count_source #(.DATA_WIDTH(8), .PKT_LEN(1), .GAP_CYCLES(0),
                        .START_VALUE(8'hFE), .INCR(8'd1)) dut_b (
        .ACLK(clk), .ARESETn(rst_n), .EN(en_b), .axis(if_b),
        .BUSY(busy_b), .PKT_COUNT(pkt_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Per-sample expectations for A right after reset release with EN=1, TREADY=1
    logic        t_vld [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [31:0] t_dat [10] = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7};
    logic        t_lst [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [15:0] t_pkt [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        logic        held, hl, rdy, found;
        logic [31:0] hd, exp_seq, d;
        int          drops;

        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        if_a.TREADY_OUT = 1'b0; if_b.TREADY_OUT = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", 32'(if_a.TVALID_OUT), 32'd0);
        chk("rst_last", 32'(if_a.TLAST_OUT), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pkt", 32'(pkt_a), 32'd0);
        chk("rst_data", if_a.TDATA_OUT, 32'd0);
        chk("rst_data_b", 32'(if_b.TDATA_OUT), 32'hFE);

        // Async reset in SEND while stalled
        rst_n = 1'b1; en_a = 1'b1; if_a.TREADY_OUT = 1'b1;
        @(negedge clk);
        chk("pre_d0", if_a.TDATA_OUT, 32'd0);
        @(negedge clk);
        chk("pre_d1", if_a.TDATA_OUT, 32'd1);
        if_a.TREADY_OUT = 1'b0;
        @(negedge clk);
        chk("pre_hold", if_a.TDATA_OUT, 32'd1);
        chk("pre_vld", 32'(if_a.TVALID_OUT), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(if_a.TVALID_OUT), 32'd0);
        chk("arst_data", if_a.TDATA_OUT, 32'd0);
        chk("arst_pkt", 32'(pkt_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);

        // Two packets with a 2-cycle gap
        @(negedge clk);
        rst_n = 1'b1; if_a.TREADY_OUT = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("pk_vld%0d", i), 32'(if_a.TVALID_OUT), 32'(t_vld[i]));
            chk($sformatf("pk_dat%0d", i), if_a.TDATA_OUT, t_dat[i]);
            chk($sformatf("pk_lst%0d", i), 32'(if_a.TLAST_OUT), 32'(t_lst[i]));
            chk($sformatf("pk_cnt%0d", i), 32'(pkt_a), 32'(t_pkt[i]));
        end

        // Sparse TREADY: hold stability and gap-free accepted sequence
        held = 1'b0; hd = '0; hl = 1'b0; exp_seq = 32'd8;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (held) begin
                chk("bp_vld", 32'(if_a.TVALID_OUT), 32'd1);
                chk("bp_data", if_a.TDATA_OUT, hd);
                chk("bp_last", 32'(if_a.TLAST_OUT), 32'(hl));
            end
            if (if_a.TVALID_OUT)
                chk("bp_lastpos", 32'(if_a.TLAST_OUT), 32'(if_a.TDATA_OUT[1:0] == 2'd3));
            rdy = (c % 6 == 5);
            if_a.TREADY_OUT = rdy;
            if (if_a.TVALID_OUT && rdy) begin
                chk("bp_seq", if_a.TDATA_OUT, exp_seq);
                exp_seq = exp_seq + 32'd1;
                held = 1'b0;
            end else if (if_a.TVALID_OUT) begin
                held = 1'b1; hd = if_a.TDATA_OUT; hl = if_a.TLAST_OUT;
            end else begin
                held = 1'b0;
            end
        end
        chk("bp_total", exp_seq, 32'd18);

        // EN dropped after beat 1 of a packet
        if_a.TREADY_OUT = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (if_a.TVALID_OUT && if_a.TDATA_OUT[1:0] == 2'd0) found = 1'b1;
        end
        chk("en_sync", 32'(found), 32'd1);
        d = if_a.TDATA_OUT;
        @(negedge clk);
        chk("en_b1", if_a.TDATA_OUT, d + 32'd1);
        @(negedge clk);
        chk("en_b2", if_a.TDATA_OUT, d + 32'd2);
        chk("en_b2_vld", 32'(if_a.TVALID_OUT), 32'd1);
        en_a = 1'b0;
        @(negedge clk);
        chk("en_b3", if_a.TDATA_OUT, d + 32'd3);
        chk("en_b3_last", 32'(if_a.TLAST_OUT), 32'd1);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            chk("en_gap_vld", 32'(if_a.TVALID_OUT), 32'd0);
            chk("en_gap_busy", 32'(busy_a), 32'd1);
        end
        @(negedge clk);
        chk("en_idle_vld", 32'(if_a.TVALID_OUT), 32'd0);
        chk("en_idle_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("en_idle2_busy", 32'(busy_a), 32'd0);
        chk("en_idle_data", if_a.TDATA_OUT, d + 32'd4);
        en_a = 1'b1;
        @(negedge clk);
        chk("en_resume_vld", 32'(if_a.TVALID_OUT), 32'd1);
        chk("en_resume_data", if_a.TDATA_OUT, d + 32'd4);
        chk("en_resume_last", 32'(if_a.TLAST_OUT), 32'd0);
        en_a = 1'b0;

        // B: 8-bit data wrap, TLAST every beat, PKT_COUNT wrap
        en_b = 1'b1; if_b.TREADY_OUT = 1'b1;
        @(negedge clk);
        chk("b_d0", 32'(if_b.TDATA_OUT), 32'hFE);
        chk("b_l0", 32'(if_b.TLAST_OUT), 32'd1);
        chk("b_p0", 32'(pkt_b), 32'd0);
        @(negedge clk);
        chk("b_d1", 32'(if_b.TDATA_OUT), 32'hFF);
        chk("b_p1", 32'(pkt_b), 32'd1);
        @(negedge clk);
        chk("b_d2", 32'(if_b.TDATA_OUT), 32'h00);
        chk("b_p2", 32'(pkt_b), 32'd2);
        @(negedge clk);
        chk("b_d3", 32'(if_b.TDATA_OUT), 32'h01);
        chk("b_v3", 32'(if_b.TVALID_OUT), 32'd1);
        chk("b_p3", 32'(pkt_b), 32'd3);
        drops = 0;
        for (int k = 5; k <= 65537; k++) begin
            @(negedge clk);
            if (!if_b.TVALID_OUT || !if_b.TLAST_OUT) drops++;
            if (k == 65536) chk("b_pkt_ffff", 32'(pkt_b), 32'hFFFF);
        end
        chk("b_pkt_wrap", 32'(pkt_b), 32'h0);
        chk("b_data_wrap", 32'(if_b.TDATA_OUT), 32'hFE);
        chk("b_drops", 32'(drops), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
